// File: rtl/mips_bus_pkg.sv
// mips_bus_pkg: shared types and helpers for the MIPS memory bus slave.
// Holds the slave FSM states, the reset vector and byte-lane merging.
package mips_bus_pkg;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    ACK
  } bus_state_t;

  localparam logic [31:0] RESET_VECTOR = 32'hBFC00000;

  function automatic logic [31:0] be_merge(
    input logic [31:0] old_w,
    input logic [31:0] new_w,
    input logic [3:0]  be
  );
    logic [31:0] r;
    r = old_w;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) r[8*i +: 8] = new_w[8*i +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/mips_bus_ram_if.sv
// mips_bus_ram_if: Avalon-style CPU memory bus bundle.
// The CPU side is master; the RAM side is slave.
interface mips_bus_ram_if;

  logic [31:0] address;
  logic        read;
  logic        write;
  logic [31:0] writedata;
  logic [3:0]  byteenable;
  logic [31:0] readdata;
  logic        waitrequest;

  modport master (
    output address, read, write,
    output writedata, byteenable,
    input  readdata, waitrequest
  );

  modport slave (
    input  address, read, write,
    input  writedata, byteenable,
    output readdata, waitrequest
  );

endinterface

// File: rtl/mips_bus_ram_array.sv
// mips_bus_ram_array: byte-lane word array.
// One synchronous write port, two asynchronous read ports.
module mips_bus_ram_array
  import mips_bus_pkg::*;
#(
  parameter int DEPTH = 1024,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [31:0]   i_wdata,
  input  logic [3:0]    i_be,
  input  logic [AW-1:0] i_raddr_a,
  output logic [31:0]   o_rdata_a,
  input  logic [AW-1:0] i_raddr_b,
  output logic [31:0]   o_rdata_b
);

  logic [31:0] r_mem [DEPTH];

  // Merge enabled lanes into the addressed word; contents survive reset.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= be_merge(r_mem[i_waddr], i_wdata, i_be);
    end
  end

  assign o_rdata_a = r_mem[i_raddr_a];
  assign o_rdata_b = r_mem[i_raddr_b];

endmodule

// File: rtl/mips_bus_ram.sv
// mips_bus_ram: wait-stated RAM slave on the CPU memory bus.
// Translates byte addresses from BASE_ADDR, flags bad accesses.
module mips_bus_ram
  import mips_bus_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = RESET_VECTOR,
  parameter int          DEPTH_WORDS = 1024,
  parameter int          WAIT_CYCLES = 1,
  localparam int         AW          = $clog2(DEPTH_WORDS)
) (
  input  logic          clk,
  input  logic          reset,
  mips_bus_ram_if.slave bus,
  input  logic [AW-1:0] dbg_addr,
  output logic [31:0]   dbg_data,
  output logic          err_proto,
  output logic          err_range
);

  localparam int          CW  = $clog2(WAIT_CYCLES + 1);
  localparam logic [31:0] WIN = 32'(DEPTH_WORDS * 4);

  bus_state_t    r_state;
  logic [CW-1:0] r_cnt;
  logic [31:0]   r_addr;
  logic [31:0]   r_wdata;
  logic [3:0]    r_be;
  logic          r_op_wr;
  logic [31:0]   r_readdata;
  logic          r_err_proto;
  logic          r_err_range;

  logic          w_req;
  logic          w_idle;
  logic [31:0]   w_addr;
  logic [3:0]    w_be;
  logic          w_op_wr;
  logic [31:0]   w_off;
  logic          w_in_win;
  logic          w_null;
  logic [AW-1:0] w_word;
  logic [31:0]   w_mem_rd;
  logic          w_enter_ack;
  logic          w_we;

  assign w_req  = bus.read | bus.write;
  assign w_idle = (r_state == IDLE);

  // In IDLE the live request is used so a one-wait-state
  // transfer can be decoded before it is latched.
  assign w_addr  = w_idle ? bus.address : r_addr;
  assign w_be    = w_idle ? bus.byteenable : r_be;
  assign w_op_wr = w_idle ? (bus.write & ~bus.read) : r_op_wr;

  assign w_off    = w_addr - BASE_ADDR;
  assign w_in_win = (w_off < WIN) && (w_addr[1:0] == 2'b00);
  assign w_null   = (w_addr == 32'd0);
  assign w_word   = w_off[AW+1:2];

  assign w_enter_ack =
    (w_idle && w_req && (WAIT_CYCLES == 1)) ||
    ((r_state == BUSY) && w_req && (r_cnt == '0));

  assign w_we = (r_state == ACK) && w_req &&
                r_op_wr && w_in_win;

  assign bus.waitrequest = w_req && (r_state != ACK);
  assign bus.readdata    = r_readdata;
  assign err_proto       = r_err_proto;
  assign err_range       = r_err_range;

  mips_bus_ram_array #(
    .DEPTH (DEPTH_WORDS),
    .AW    (AW)
  ) u_array (
    .clk       (clk),
    .i_we      (w_we),
    .i_waddr   (w_word),
    .i_wdata   (r_wdata),
    .i_be      (r_be),
    .i_raddr_a (dbg_addr),
    .o_rdata_a (dbg_data),
    .i_raddr_b (w_word),
    .o_rdata_b (w_mem_rd)
  );

  // Handshake FSM: accept, count wait states, acknowledge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_be        <= '0;
      r_op_wr     <= 1'b0;
      r_err_proto <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (w_req) begin
            r_addr  <= bus.address;
            r_wdata <= bus.writedata;
            r_be    <= bus.byteenable;
            r_op_wr <= w_op_wr;
            if (bus.read && bus.write) r_err_proto <= 1'b1;
            if (WAIT_CYCLES == 1) begin
              r_state <= ACK;
            end else begin
              r_cnt   <= CW'(WAIT_CYCLES - 2);
              r_state <= BUSY;
            end
          end
        end
        BUSY: begin
          if (!w_req) begin
            r_err_proto <= 1'b1;
            r_state     <= IDLE;
          end else if (r_cnt == '0) begin
            r_state <= ACK;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        ACK: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  // Register read data and range errors as a transfer enters ACK.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_readdata  <= '0;
      r_err_range <= 1'b0;
    end else if (w_enter_ack) begin
      r_readdata <= (!w_op_wr && w_in_win) ?
                    be_merge(32'h0, w_mem_rd, w_be) : 32'h0;
      if (!w_in_win && !(w_null && !w_op_wr)) begin
        r_err_range <= 1'b1;
      end
    end
  end

endmodule
